// File: rtl/rcc_sys_clk_sw_ctrl.sv
// System clock source switch sequencer: ready wait, gate, switch, settle, ungate, with CSS fallback to HSI.
// Optional stop-entry wake-source switching is enabled by defining RCC_SYS_CLK_STOP_WAKE_EN.
module rcc_sys_clk_sw_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RDY_TIMEOUT   = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       hsi_clk,
  input  logic       sys_rst,
  input  logic [1:0] sw_req,
  input  logic       sw_wr,
  input  logic [3:0] src_rdy,
  input  logic       css_fail,
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
  input  logic       stop_entry,
  input  logic       stopwuck,
`endif
  output logic [1:0] sys_clk_sw,
  output logic       sys_clk_gate_en,
  output logic [1:0] sws,
  output logic       sw_busy,
  output logic       sw_err,
  output logic       css_flag
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_RDY    = 2'd1,
    ST_GATE_PRE    = 2'd2,
    ST_SWITCH_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RDY_TIMEOUT - 32'd1);
  localparam logic [1:0]       SRC_HSI     = 2'd0;
  localparam logic [1:0]       SRC_HSE     = 2'd2;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_target;
  logic [1:0]       r_sel;
  logic [1:0]       r_sws;
  logic             r_gate;
  logic             r_busy;
  logic             r_err;
  logic             r_css_flag;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_target_nxt;
  logic [1:0]       w_sel_nxt;
  logic [1:0]       w_sws_nxt;
  logic             w_gate_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;
  logic             w_css_flag_nxt;
  logic             w_req_vld;
  logic [1:0]       w_req_src;
  logic             w_gated_hsi;
  logic             w_css_hit;

  // An HSI fallback already in its gate/hold phase must not be restarted by a still-asserted css_fail.
  assign w_gated_hsi = (r_target == SRC_HSI) &&
                       ((r_state == ST_GATE_PRE) || (r_state == ST_SWITCH_HOLD));
  assign w_css_hit   = css_fail && ((r_sws == SRC_HSE) || (r_busy && (r_target == SRC_HSE))) &&
                       !w_gated_hsi;

  // Qualify a new switch request from software or, optionally, stop entry.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_src = sw_req;
    if (sw_wr) begin
      w_req_src = sw_req;
      w_req_vld = (sw_req != r_sws) && !(css_fail && (sw_req == SRC_HSE));
    end
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
    else if (stop_entry) begin
      w_req_src = {1'b0, stopwuck};
      w_req_vld = ({1'b0, stopwuck} != r_sws);
    end
`endif
    else begin
      w_req_src = sw_req;
      w_req_vld = 1'b0;
    end
  end

  // Next-state and next-output computation for the switch sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_target_nxt   = r_target;
    w_sel_nxt      = r_sel;
    w_sws_nxt      = r_sws;
    w_gate_nxt     = r_gate;
    w_busy_nxt     = r_busy;
    w_err_nxt      = 1'b0;
    w_css_flag_nxt = r_css_flag;
    if (sw_wr) begin
      w_css_flag_nxt = 1'b0;
    end else begin
      w_css_flag_nxt = r_css_flag;
    end
    if (w_css_hit) begin
      w_target_nxt   = SRC_HSI;
      w_busy_nxt     = 1'b1;
      w_css_flag_nxt = 1'b1;
      w_cnt_nxt      = {CNT_W{1'b0}};
      case (r_state)
        ST_GATE_PRE: begin
          w_state_nxt = ST_GATE_PRE;
        end
        ST_SWITCH_HOLD: begin
          // Select already moved to HSE; gate is low, so retarget now and hold a full settle.
          w_state_nxt = ST_SWITCH_HOLD;
          w_sel_nxt   = SRC_HSI;
        end
        default: begin
          w_state_nxt = ST_GATE_PRE;
          w_gate_nxt  = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = {CNT_W{1'b0}};
          if (w_req_vld) begin
            w_target_nxt = w_req_src;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = ST_WAIT_RDY;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT_RDY: begin
          if (src_rdy[r_target]) begin
            w_state_nxt = ST_GATE_PRE;
            w_gate_nxt  = 1'b0;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else if (r_cnt == TMO_LAST) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_GATE_PRE: begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_nxt = ST_SWITCH_HOLD;
            w_sel_nxt   = r_target;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_SWITCH_HOLD: begin
          if (r_cnt == SETTLE_LAST) begin
            w_state_nxt = ST_IDLE;
            w_gate_nxt  = 1'b1;
            w_sws_nxt   = r_target;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers; reset leaves HSI selected with the clock running.
  always_ff @(posedge hsi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_target   <= 2'd0;
      r_sel      <= 2'd0;
      r_sws      <= 2'd0;
      r_gate     <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_css_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_target   <= w_target_nxt;
      r_sel      <= w_sel_nxt;
      r_sws      <= w_sws_nxt;
      r_gate     <= w_gate_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_css_flag <= w_css_flag_nxt;
    end
  end

  assign sys_clk_sw      = r_sel;
  assign sys_clk_gate_en = r_gate;
  assign sws             = r_sws;
  assign sw_busy         = r_busy;
  assign sw_err          = r_err;
  assign css_flag        = r_css_flag;

endmodule

// File: tb/tb_rcc_sys_clk_sw_ctrl.sv
// Directed self-checking bench for rcc_sys_clk_sw_ctrl (SETTLE_CYCLES=4, RDY_TIMEOUT=1024).
module tb_rcc_sys_clk_sw_ctrl;

  logic       hsi_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] sw_req;
  logic       sw_wr;
  logic [3:0] src_rdy;
  logic       css_fail;
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
  logic       stop_entry;
  logic       stopwuck;
`endif
  logic [1:0] sys_clk_sw;
  logic       sys_clk_gate_en;
  logic [1:0] sws;
  logic       sw_busy;
  logic       sw_err;
  logic       css_flag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] w_obs;
  logic [7:0] e;
  assign w_obs = {sys_clk_sw, sys_clk_gate_en, sws, sw_busy, sw_err, css_flag};

  rcc_sys_clk_sw_ctrl #(
    .SETTLE_CYCLES(4),
    .RDY_TIMEOUT  (1024),
    .CNT_W        (16)
  ) dut (
    .hsi_clk        (hsi_clk),
    .sys_rst        (sys_rst),
    .sw_req         (sw_req),
    .sw_wr          (sw_wr),
    .src_rdy        (src_rdy),
    .css_fail       (css_fail),
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
    .stop_entry     (stop_entry),
    .stopwuck       (stopwuck),
`endif
    .sys_clk_sw     (sys_clk_sw),
    .sys_clk_gate_en(sys_clk_gate_en),
    .sws            (sws),
    .sw_busy        (sw_busy),
    .sw_err         (sw_err),
    .css_flag       (css_flag)
  );

  always #5 hsi_clk = ~hsi_clk;

  // Expected output vector {sys_clk_sw, gate_en, sws, busy, err, css_flag}.
  function automatic logic [7:0] expv(input logic [1:0] sel, input logic gate, input logic [1:0] s,
                                      input logic busy, input logic err, input logic flag);
    return {sel, gate, s, busy, err, flag};
  endfunction

  task automatic tick();
    @(negedge hsi_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; sw_wr = 1'b0; sw_req = 2'd0; src_rdy = 4'b0000; css_fail = 1'b0;
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
    stop_entry = 1'b0; stopwuck = 1'b0;
`endif
    tick(); tick();
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_held: got %b expected %b", w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    sys_rst = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_released: got %b expected %b", w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_switch_pll();
    src_rdy = 4'b1001; sw_req = 2'd3; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      e = expv((k >= 6) ? 2'd3 : 2'd0, !(k >= 2 && k <= 9), (k >= 10) ? 2'd3 : 2'd0, (k <= 9), 1'b0, 1'b0);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL switch_pll cycle %0d: got %b expected %b", k, w_obs, e);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    src_rdy = 4'b1001; sw_req = 2'd2; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    for (int k = 1; k <= 1026; k++) begin
      e = expv(2'd3, 1'b1, 2'd3, (k <= 1024), (k == 1025), 1'b0);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL timeout cycle %0d: got %b expected %b", k, w_obs, e);
      end
      tick();
    end
  endtask

  task automatic test_css_fallback();
    src_rdy = 4'b0101; sw_req = 2'd2; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0) &&
        w_obs !== expv(2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL css_setup_hse: got %b expected sws=2 idle", w_obs);
    end
    n_checks++;
    if (sys_clk_sw !== 2'd2) begin
      n_fail++; $display("FAIL css_setup_sel: got %0d expected 2", sys_clk_sw);
    end
    css_fail = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      e = expv((k >= 5) ? 2'd0 : 2'd2, (k == 9), (k == 9) ? 2'd0 : 2'd2, (k <= 8), 1'b0, 1'b1);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL css_fallback cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k == 9) css_fail = 1'b0;
      tick();
    end
    sw_req = 2'd0; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL css_flag_clear: got %b expected %b", w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_css_gate_pre();
    src_rdy = 4'b0101; sw_req = 2'd2; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      e = expv(2'd0, !(k >= 2 && k <= 11), 2'd0, (k <= 11), 1'b0, (k >= 4));
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL css_gate_pre cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k == 3) css_fail = 1'b1;
      tick();
    end
    css_fail = 1'b0; sw_req = 2'd0; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    n_checks++;
    if (css_flag !== 1'b0) begin
      n_fail++; $display("FAIL css_gate_pre_clear: got %b expected 0", css_flag);
    end
  endtask

  task automatic test_css_block();
    css_fail = 1'b1; src_rdy = 4'b0101; sw_req = 2'd2; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL css_block cycle %0d: got %b expected %b", k, w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
      end
      tick();
    end
    css_fail = 1'b0;
  endtask

  task automatic test_back_to_back();
    sw_req = 2'd0; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL noop cycle %0d: got %b expected %b", k, w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
      end
      tick();
    end
    src_rdy = 4'b1011; sw_req = 2'd1; sw_wr = 1'b1;
    tick();
    sw_req = 2'd3;
    for (int k = 1; k <= 13; k++) begin
      e = expv((k >= 6) ? 2'd1 : 2'd0, !(k >= 2 && k <= 9), (k >= 10) ? 2'd1 : 2'd0, (k <= 9), 1'b0, 1'b0);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: got %b expected %b", k, w_obs, e);
      end
      sw_wr = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    src_rdy = 4'b1011; sw_req = 2'd3; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (w_obs !== expv(2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_hold: got %b expected %b", w_obs, expv(2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0));
    end
    #2 sys_rst = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_async: got %b expected %b", w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    end
    tick(); sys_rst = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_mid_after: got %b expected %b", w_obs, expv(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    end
  endtask

`ifdef RCC_SYS_CLK_STOP_WAKE_EN
  task automatic test_stop_wake();
    src_rdy = 4'b1011; sw_req = 2'd3; sw_wr = 1'b1;
    tick(); sw_wr = 1'b0;
    repeat (9) tick();
    n_checks++;
    if (w_obs !== expv(2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL stop_setup: got %b expected %b", w_obs, expv(2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0));
    end
    stopwuck = 1'b1; stop_entry = 1'b1;
    tick(); stop_entry = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      e = expv((k >= 6) ? 2'd1 : 2'd3, !(k >= 2 && k <= 9), (k >= 10) ? 2'd1 : 2'd3, (k <= 9), 1'b0, 1'b0);
      n_checks++;
      if (w_obs !== e) begin
        n_fail++; $display("FAIL stop_wake cycle %0d: got %b expected %b", k, w_obs, e);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_switch_pll();
    test_timeout();
    test_reset();
    test_css_fallback();
    test_css_gate_pre();
    test_css_block();
    test_back_to_back();
    test_reset_mid();
`ifdef RCC_SYS_CLK_STOP_WAKE_EN
    test_stop_wake();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
